trdb_packet_scheduler: RTL and testbench
========================================

// Module: trdb_packet_scheduler
// PURPOSE
// Sequences the packet emitter: collects packet requests from the trace filter/priority stage, holds them
// pending, picks one per transaction by fixed priority, drives format/subformat + valid to the emitter, and
// completes on the encapsulator's ready. Also generates branch-map flush and periodic resync requests.
// PARAMETERS
// RESYNC_MAX  256                   packets emitted between forced F_SYNC/SF_START (macro-gated)
// CNT_W       $clog2(RESYNC_MAX+1)  resync counter width (derived, not overridden)
// PORTS
// clk_i               in   1   clock
// rst_ni              in   1   reset; one clock; reset is asynchronous and active-low
// enable_i            in   1   trace encoder enabled (ienable)
// delta_address_i     in   1   1: address requests emit F_DIFF_DELTA; 0: F_ADDR_ONLY
// req_support_i       in   1   request F_SYNC/SF_SUPPORT (1-cycle pulse)
// req_trap_i          in   1   request F_SYNC/SF_TRAP
// req_start_i         in   1   request F_SYNC/SF_START
// req_context_i       in   1   request F_SYNC/SF_CONTEXT
// req_addr_i          in   1   request address packet (format 1 or 2)
// ready_i             in   1   encapsulator accepts current packet
// valid_o             out  1   drives emitter valid_i
// packet_format_o     out  2   trdb_format_e to emitter
// packet_subformat_o  out  2   trdb_f_sync_subformat_e to emitter (0 when format != F_SYNC)
// branch_map_flush_o  out  1   1-cycle pulse the cycle after each completed handshake
// req_merged_o        out  1   1-cycle pulse: request coalesced into an already-pending one
// busy_o              out  1   transaction in flight or any request pending
// BEHAVIOUR
// - Reset: all outputs 0 (format F_OPT_EXT=0, subformat SF_START=0); pending flags 0; FSM IDLE; counter 0.
// - Pending: 5 sticky flags {support,trap,start,context,addr}; req pulse sets flag at clock edge.
//   req for a flag already set (and not cleared this cycle) -> flag stays 1, req_merged_o=1 next cycle.
// - Rising edge of enable_i (registered compare) sets support and start pending.
// - Priority: support > trap > start > context > addr.
// - FSM IDLE: if enable_i and any flag -> register winner into format/subformat, go ISSUE.
//   ISSUE: valid_o=1; format/subformat stable; on ready_i: clear winner flag, go FLUSH.
//   FLUSH: valid_o=0, branch_map_flush_o=1 for exactly this cycle, go IDLE.
// - Latency: req at cycle N -> pending edge N -> IDLE select N+1 -> valid_o at N+2. Min 3 cycles/packet.
// - valid_o never drops before ready_i (no retraction); ready_i outside ISSUE ignored.
// - Same-type req in handshake cycle: flag cleared then re-set (new request), no merge pulse.
// - addr selection samples delta_address_i in IDLE; later changes do not alter an issued packet.
// - enable_i falls: pending flags cleared; an in-flight ISSUE completes normally, then IDLE with no issue.
// - Async reset mid-ISSUE: valid_o drops immediately, all state cleared.
// CONFIGURATION
// - `TRDB_PERIODIC_RESYNC_EN defined: CNT_W counter increments per handshake of non-SF_START packets,
//   clears on SF_START handshake or enable rising edge; reaching RESYNC_MAX sets start pending, counter
//   clears, saturates (no wrap) while start pending.
// - Undefined: no counter logic; start pending only from req_start_i/enable edge.
// STRUCTURE
// - trdb_pkg: trdb_format_e, trdb_f_sync_subformat_e (existing), new trdb_sched_state_e {IDLE,ISSUE,FLUSH},
//   RESYNC_MAX default constant.
// - One sub-module: trdb_prio_picker (combinational fixed-priority one-hot select of pending flags).
// TESTING
// - Reset then enable_i 0->1, ready_i=1 -> SF_SUPPORT valid at cycle 2, then SF_START, flush pulses after each.
// - req_addr_i+req_trap_i same cycle, delta_address_i=1 -> F_SYNC/SF_TRAP first, then F_DIFF_DELTA (1).
// - ready_i held 0 for 10 cycles in ISSUE -> valid_o/format stable for 10 cycles, no flush until ready.
// - req_context_i twice while pending -> req_merged_o one pulse, exactly one SF_CONTEXT packet.
// - enable_i drop during ISSUE with trap+addr pending -> current packet completes, nothing further issued.
// - TRDB_PERIODIC_RESYNC_EN, RESYNC_MAX=4: 4 address packets -> 5th packet F_SYNC/SF_START; unset: none.

Source files
------------

// File: rtl/trdb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trdb_pkg: packet format encodings and scheduler types for the trace      |
// | encoder packet path.                                   Revision: 1.0     |
// +--------------------------------------------------------------------------+
package trdb_pkg;

   typedef enum logic [1:0] {
      F_OPT_EXT    = 2'd0,
      F_DIFF_DELTA = 2'd1,
      F_ADDR_ONLY  = 2'd2,
      F_SYNC       = 2'd3
   } trdb_format_e;

   typedef enum logic [1:0] {
      SF_START   = 2'd0,
      SF_TRAP    = 2'd1,
      SF_CONTEXT = 2'd2,
      SF_SUPPORT = 2'd3
   } trdb_f_sync_subformat_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      FLUSH = 2'd2
   } trdb_sched_state_e;

   localparam int unsigned RESYNC_MAX_DEFAULT = 256;

   // Pending-flag bit positions; a higher index means a higher priority.
   localparam int unsigned NUM_REQ     = 5;
   localparam int unsigned REQ_SUPPORT = 4;
   localparam int unsigned REQ_TRAP    = 3;
   localparam int unsigned REQ_START   = 2;
   localparam int unsigned REQ_CONTEXT = 1;
   localparam int unsigned REQ_ADDR    = 0;

   function automatic logic [3:0] encode_packet(input logic [NUM_REQ-1:0] grant,
                                                input logic               delta);
      trdb_format_e           fmt;
      trdb_f_sync_subformat_e sub;
      fmt = F_SYNC;
      sub = SF_START;
      if (grant[REQ_SUPPORT]) begin
         sub = SF_SUPPORT;
      end else if (grant[REQ_TRAP]) begin
         sub = SF_TRAP;
      end else if (grant[REQ_CONTEXT]) begin
         sub = SF_CONTEXT;
      end else if (grant[REQ_ADDR]) begin
         fmt = delta ? F_DIFF_DELTA : F_ADDR_ONLY;
      end
      return {fmt, sub};
   endfunction

endpackage
`default_nettype wire

// File: rtl/trdb_prio_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trdb_prio_picker: fixed-priority one-hot select of pending requests.     |
// |                                                        Revision: 1.0     |
// +--------------------------------------------------------------------------+
module trdb_prio_picker
   import trdb_pkg::*;
(
   input  logic [NUM_REQ-1:0] pending,
   output logic [NUM_REQ-1:0] grant
);

   // Scanning upward lets the highest set index overwrite any lower one.
   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pending[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/trdb_packet_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trdb_packet_scheduler: holds packet requests, issues one per handshake   |
// | by fixed priority. Option macro: TRDB_PERIODIC_RESYNC_EN. Revision: 1.0  |
// +--------------------------------------------------------------------------+
module trdb_packet_scheduler
   import trdb_pkg::*;
#(
   parameter int unsigned RESYNC_MAX = RESYNC_MAX_DEFAULT
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       enable_i,
   input  logic       delta_address_i,
   input  logic       req_support_i,
   input  logic       req_trap_i,
   input  logic       req_start_i,
   input  logic       req_context_i,
   input  logic       req_addr_i,
   input  logic       ready_i,
   output logic       valid_o,
   output logic [1:0] packet_format_o,
   output logic [1:0] packet_subformat_o,
   output logic       branch_map_flush_o,
   output logic       req_merged_o,
   output logic       busy_o
);

   trdb_sched_state_e  state;
   logic               enable_q;
   logic [NUM_REQ-1:0] pending;
   logic [NUM_REQ-1:0] pending_next;
   logic [NUM_REQ-1:0] req_vec;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] sel;
   logic [NUM_REQ-1:0] clr;
   logic [NUM_REQ-1:0] auto_set;
   logic               enable_rise;
   logic               handshake;
   logic               resync_set;
   logic               merge_next;

   if (RESYNC_MAX < 1) begin : g_resync_max_check
      $error("RESYNC_MAX must be at least 1");
   end

   assign req_vec     = {req_support_i, req_trap_i, req_start_i, req_context_i, req_addr_i};
   assign enable_rise = enable_i & ~enable_q;
   assign handshake   = (state == ISSUE) & ready_i;
   assign clr         = handshake ? sel : '0;

   trdb_prio_picker u_picker (
      .pending (pending),
      .grant   (grant)
   );

`ifdef TRDB_PERIODIC_RESYNC_EN
   localparam int unsigned CNT_W = $clog2(RESYNC_MAX + 1);
   logic [CNT_W-1:0] resync_cnt;

   assign resync_set = (resync_cnt == CNT_W'(RESYNC_MAX));

   // Holding while a start is already pending keeps the count from passing RESYNC_MAX.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         resync_cnt <= '0;
      end else if (enable_rise || resync_set) begin
         resync_cnt <= '0;
      end else if (handshake) begin
         if (sel[REQ_START]) begin
            resync_cnt <= '0;
         end else if (!pending[REQ_START]) begin
            resync_cnt <= resync_cnt + CNT_W'(1);
         end
      end
   end
`else
   assign resync_set = 1'b0;
`endif

   always_comb begin
      auto_set              = '0;
      auto_set[REQ_SUPPORT] = enable_rise;
      auto_set[REQ_START]   = enable_rise | resync_set;
   end

   // A flag being retired this cycle is not a merge target: a same-cycle request is new work.
   assign pending_next = enable_i ? ((pending & ~clr) | req_vec | auto_set) : '0;
   assign merge_next   = enable_i & (|(req_vec & pending & ~clr));
   assign busy_o       = (state != IDLE) | (|pending);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         enable_q     <= 1'b0;
         pending      <= '0;
         req_merged_o <= 1'b0;
      end else begin
         enable_q     <= enable_i;
         pending      <= pending_next;
         req_merged_o <= merge_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state              <= IDLE;
         sel                <= '0;
         valid_o            <= 1'b0;
         packet_format_o    <= F_OPT_EXT;
         packet_subformat_o <= SF_START;
         branch_map_flush_o <= 1'b0;
      end else begin
         branch_map_flush_o <= 1'b0;
         case (state)
            IDLE: begin
               if (enable_i && (|pending)) begin
                  sel                                   <= grant;
                  {packet_format_o, packet_subformat_o} <= encode_packet(grant, delta_address_i);
                  valid_o                               <= 1'b1;
                  state                                 <= ISSUE;
               end
            end
            ISSUE: begin
               if (ready_i) begin
                  valid_o            <= 1'b0;
                  branch_map_flush_o <= 1'b1;
                  state              <= FLUSH;
               end
            end
            FLUSH: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_trdb_packet_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_trdb_packet_scheduler: table-driven and scoreboard bench for the      |
// | packet scheduler.                                      Revision: 1.0     |
// +--------------------------------------------------------------------------+
module tb_trdb_packet_scheduler;

   // {format, subformat} encodings of the packets the emitter should see.
   localparam logic [3:0] P_SUP   = 4'hF;
   localparam logic [3:0] P_TRAP  = 4'hD;
   localparam logic [3:0] P_START = 4'hC;
   localparam logic [3:0] P_CTX   = 4'hE;
   localparam logic [3:0] P_ADDR  = 4'h8;
   localparam logic [3:0] P_DELTA = 4'h4;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b1;
   logic       enable_i = 1'b0;
   logic       delta_address_i = 1'b0;
   logic       req_support_i = 1'b0;
   logic       req_trap_i = 1'b0;
   logic       req_start_i = 1'b0;
   logic       req_context_i = 1'b0;
   logic       req_addr_i = 1'b0;
   logic       ready_i = 1'b0;
   logic       valid_o;
   logic [1:0] packet_format_o;
   logic [1:0] packet_subformat_o;
   logic       branch_map_flush_o;
   logic       req_merged_o;
   logic       busy_o;

   int         total = 0;
   int         bad = 0;
   int         merged_cnt = 0;
   logic [3:0] exp_q[$];
   logic       prev_hs = 1'b0;
   logic       prev_stall = 1'b0;
   logic [3:0] prev_pkt = 4'h0;

   typedef struct {
      logic [4:0] req;
      logic       delta;
      int         n;
      logic [3:0] p0;
      logic [3:0] p1;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   trdb_packet_scheduler #(.RESYNC_MAX(4)) dut (
      .clk_i              (clk),
      .rst_ni             (rst_ni),
      .enable_i           (enable_i),
      .delta_address_i    (delta_address_i),
      .req_support_i      (req_support_i),
      .req_trap_i         (req_trap_i),
      .req_start_i        (req_start_i),
      .req_context_i      (req_context_i),
      .req_addr_i         (req_addr_i),
      .ready_i            (ready_i),
      .valid_o            (valid_o),
      .packet_format_o    (packet_format_o),
      .packet_subformat_o (packet_subformat_o),
      .branch_map_flush_o (branch_map_flush_o),
      .req_merged_o       (req_merged_o),
      .busy_o             (busy_o)
   );

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard side: every accepted packet must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_ni) begin
         check("flush_after_hs", branch_map_flush_o, prev_hs);
         if (prev_stall) begin
            check("hold_valid", valid_o, 1);
            check("hold_pkt", {packet_format_o, packet_subformat_o}, prev_pkt);
         end
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0)
               check("unexpected_pkt", {packet_format_o, packet_subformat_o}, 16);
            else
               check("pkt", {packet_format_o, packet_subformat_o}, exp_q.pop_front());
         end
         if (req_merged_o) merged_cnt <= merged_cnt + 1;
         prev_hs    <= valid_o && ready_i;
         prev_stall <= valid_o && !ready_i;
         prev_pkt   <= {packet_format_o, packet_subformat_o};
      end
   end

   task automatic pulse(input logic [4:0] r);
      @(posedge clk); #1;
      {req_support_i, req_trap_i, req_start_i, req_context_i, req_addr_i} = r;
      @(posedge clk); #1;
      {req_support_i, req_trap_i, req_start_i, req_context_i, req_addr_i} = 5'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy_o && n < 200);
      check({name, "_idle"}, busy_o, 0);
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!valid_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({name, "_valid"}, valid_o, 1);
   endtask

   // Re-enabling queues support then start and restarts any resync count.
   task automatic reenable();
      @(posedge clk); #1;
      enable_i = 1'b0;
      ready_i  = 1'b1;
      repeat (2) @(posedge clk);
      #1 enable_i = 1'b1;
      exp_q.push_back(P_SUP);
      exp_q.push_back(P_START);
      @(posedge clk); #1;
      wait_idle("reenable");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int held;
      int m0;

      vecs[0] = '{5'b00001, 1'b0, 1, P_ADDR,  4'h0};
      vecs[1] = '{5'b00001, 1'b1, 1, P_DELTA, 4'h0};
      vecs[2] = '{5'b01001, 1'b1, 2, P_TRAP,  P_DELTA};
      vecs[3] = '{5'b00010, 1'b0, 1, P_CTX,   4'h0};
      vecs[4] = '{5'b10010, 1'b0, 2, P_SUP,   P_CTX};
      vecs[5] = '{5'b00101, 1'b0, 2, P_START, P_ADDR};
      vecs[6] = '{5'b01100, 1'b0, 2, P_TRAP,  P_START};

      #1 rst_ni = 1'b0;
      @(negedge clk);
      check("reset_outputs", {valid_o, packet_format_o, packet_subformat_o,
                              branch_map_flush_o, req_merged_o, busy_o}, 0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst_ni = 1'b1;
      @(negedge clk);
      check("disabled_busy", busy_o, 0);

      // Enable edge: support first, start next, valid two edges after the rise is sampled.
      ready_i = 1'b1;
      @(posedge clk); #1 enable_i = 1'b1;
      exp_q.push_back(P_SUP);
      exp_q.push_back(P_START);
      @(negedge clk);
      check("lat_c0_valid", valid_o, 0);
      @(negedge clk);
      check("lat_c1_valid", valid_o, 0);
      check("lat_c1_busy", busy_o, 1);
      @(negedge clk);
      check("lat_c2_valid", valid_o, 1);
      check("lat_c2_pkt", {packet_format_o, packet_subformat_o}, P_SUP);
      wait_idle("enable_seq");

      for (int i = 0; i < 7; i++) begin
         reenable();
         delta_address_i = vecs[i].delta;
         exp_q.push_back(vecs[i].p0);
         if (vecs[i].n > 1) exp_q.push_back(vecs[i].p1);
         pulse(vecs[i].req);
         wait_idle($sformatf("vec%0d", i));
      end
      check("no_spurious_merge", merged_cnt, 0);

      // Stall: ten cycles without ready must hold the packet and withhold the flush.
      reenable();
      ready_i = 1'b0;
      exp_q.push_back(P_CTX);
      pulse(5'b00010);
      wait_valid("stall");
      held = 0;
      repeat (10) begin
         @(negedge clk);
         if (valid_o && !branch_map_flush_o && {packet_format_o, packet_subformat_o} == P_CTX)
            held++;
      end
      check("stall_held_cycles", held, 10);
      @(posedge clk); #1 ready_i = 1'b1;
      wait_idle("stall");

      // Merge: second context request while pending.
      reenable();
      ready_i = 1'b0;
      m0 = merged_cnt;
      exp_q.push_back(P_CTX);
      pulse(5'b00010);
      pulse(5'b00010);
      repeat (3) @(negedge clk);
      @(posedge clk); #1 ready_i = 1'b1;
      wait_idle("merge");
      check("merge_pulses", merged_cnt - m0, 1);

      // Enable drop mid-ISSUE: the trap completes, the pending addr is discarded.
      reenable();
      ready_i = 1'b0;
      delta_address_i = 1'b0;
      exp_q.push_back(P_TRAP);
      pulse(5'b01001);
      wait_valid("drop");
      check("drop_issue_pkt", {packet_format_o, packet_subformat_o}, P_TRAP);
      @(posedge clk); #1 enable_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 ready_i = 1'b1;
      wait_idle("drop");
      repeat (6) @(negedge clk);
      check("drop_no_issue", valid_o, 0);

      // Periodic resync: four non-start packets force a start packet when enabled.
      reenable();
      delta_address_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(P_ADDR);
`ifdef TRDB_PERIODIC_RESYNC_EN
         if (k == 3) exp_q.push_back(P_START);
`endif
         pulse(5'b00001);
         wait_idle($sformatf("resync%0d", k));
      end
      exp_q.push_back(P_ADDR);
      pulse(5'b00001);
      wait_idle("resync_last");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
